// File: rtl/float_alu_core.sv
// Multi-cycle binary32/binary16 floating-point add/subtract unit.
// One operation in flight; the stages UNPACK..ROUND take one cycle each, then OUT holds the result until it is consumed.
module float_alu_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [2:0]  op_code,
  input  logic        round_mode,
  input  logic        mode_fp,
  input  logic        start,
  input  logic        ready_in,
  output logic        valid_out,
  output logic        ready_out,
  output logic [31:0] result,
  output logic [4:0]  flags
);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_OUT
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] man;
    logic        is_inf;
    logic        is_nan;
    logic        is_snan;
  } unp_t;

  // binary16 mantissas are left-justified into the 24-bit field so both formats share one datapath
  function automatic unp_t unpack(input logic [31:0] x, input logic fp32);
    unp_t u;
    if (fp32) begin
      u.sign    = x[31];
      u.exp     = (x[30:23] == '0) ? 10'd1 : {2'b00, x[30:23]};
      u.man     = {x[30:23] != '0, x[22:0]};
      u.is_inf  = (x[30:23] == '1) && (x[22:0] == '0);
      u.is_nan  = (x[30:23] == '1) && (x[22:0] != '0);
      u.is_snan = u.is_nan && !x[22];
    end else begin
      u.sign    = x[15];
      u.exp     = (x[14:10] == '0) ? 10'd1 : {5'b00000, x[14:10]};
      u.man     = {x[14:10] != '0, x[9:0], 13'b0};
      u.is_inf  = (x[14:10] == '1) && (x[9:0] == '0);
      u.is_nan  = (x[14:10] == '1) && (x[9:0] != '0);
      u.is_snan = u.is_nan && !x[9];
    end
    return u;
  endfunction

  function automatic logic [31:0] inf_of(input logic s, input logic fp32);
    return fp32 ? {s, 8'hFF, 23'h0} : {16'h0, s, 5'h1F, 10'h0};
  endfunction

  function automatic logic [31:0] maxf_of(input logic s, input logic fp32);
    return fp32 ? {s, 8'hFE, 23'h7FFFFF} : {16'h0, s, 5'h1E, 10'h3FF};
  endfunction

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic        ready_q, ready_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  flags_q, flags_d;

  logic [31:0] a_q, a_d, b_q, b_d;
  logic [2:0]  opc_q, opc_d;
  logic        rm_q, rm_d, fp32_q, fp32_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic [9:0]  ea_q, ea_d, eb_q, eb_d;
  logic [23:0] ma_q, ma_d, mb_q, mb_d;
  logic        spec_q, spec_d;
  logic [31:0] spec_res_q, spec_res_d;
  logic [4:0]  spec_flg_q, spec_flg_d;
  logic        sgn_q, sgn_d, sub_q, sub_d;
  logic [9:0]  exp_q, exp_d;
  logic [23:0] big_q, big_d;
  logic [26:0] small_q, small_d;
  logic [27:0] sum_q, sum_d;
  logic [26:0] norm_q, norm_d;

  // UNPACK stage: classification and special-case outcome
  unp_t        ua, ub;
  logic        up_sb, up_spec;
  logic [31:0] up_res;
  logic [4:0]  up_flg;

  always_comb begin
    ua      = unpack(a_q, fp32_q);
    ub      = unpack(b_q, fp32_q);
    up_sb   = ub.sign ^ (opc_q == OP_SUB);
    up_spec = 1'b1;
    up_res  = fp32_q ? 32'h7FC0_0000 : 32'h0000_7E00;
    up_flg  = 5'b10000;
    if (opc_q == OP_ADD || opc_q == OP_SUB) begin
      if (ua.is_nan || ub.is_nan) begin
        up_flg = {ua.is_snan || ub.is_snan, 4'b0000};
      end else if (ua.is_inf && ub.is_inf && (ua.sign != up_sb)) begin
        up_flg = 5'b10000;
      end else if (ua.is_inf) begin
        up_res = inf_of(ua.sign, fp32_q);
        up_flg = '0;
      end else if (ub.is_inf) begin
        up_res = inf_of(up_sb, fp32_q);
        up_flg = '0;
      end else begin
        up_spec = 1'b0;
        up_flg  = '0;
      end
    end
  end

  // ALIGN stage: larger magnitude first, smaller shifted right with guard/round/sticky
  logic        al_swap;
  logic [9:0]  al_diff;
  logic [23:0] al_big, al_sml;
  logic [49:0] al_shift;
  logic [26:0] al_small;

  always_comb begin
    al_swap  = {eb_q, mb_q} > {ea_q, ma_q};
    al_big   = al_swap ? mb_q : ma_q;
    al_sml   = al_swap ? ma_q : mb_q;
    al_diff  = al_swap ? (eb_q - ea_q) : (ea_q - eb_q);
    al_shift = {al_sml, 26'b0} >> al_diff;
    if (al_diff > 10'd26) al_small = {26'b0, |al_sml};
    else                  al_small = {al_shift[49:24], |al_shift[23:0]};
  end

  // NORM stage
  logic [4:0]  nm_lz;
  logic [9:0]  nm_lim, nm_sh, nm_exp;
  logic [26:0] nm_man;

  always_comb begin
    nm_lz = 5'd27;
    for (int unsigned i = 0; i < 27; i++) begin
      if (sum_q[i]) nm_lz = 5'(26 - i);
    end
    nm_lim = exp_q - 10'd1;
    nm_sh  = ({5'b0, nm_lz} > nm_lim) ? nm_lim : {5'b0, nm_lz};
    if (sum_q[27]) begin
      nm_man = {sum_q[27:2], sum_q[1] | sum_q[0]};
      nm_exp = exp_q + 10'd1;
    end else begin
      nm_man = sum_q[26:0] << nm_sh;
      nm_exp = exp_q - nm_sh;
    end
  end

  // ROUND stage; binary16 keeps norm[26:16], binary32 keeps norm[26:3]
  logic [23:0] rd_kept, rd_man;
  logic        rd_g, rd_r, rd_s, rd_inc, rd_cy, rd_hid, rd_nx, rd_sign, rd_ovf;
  logic [24:0] rd_sum;
  logic [9:0]  rd_exp, rd_ef;
  logic [31:0] rd_res;
  logic [4:0]  rd_flg;

  always_comb begin
    rd_kept = fp32_q ? norm_q[26:3] : {13'b0, norm_q[26:16]};
    rd_g    = fp32_q ? norm_q[2] : norm_q[15];
    rd_r    = fp32_q ? norm_q[1] : norm_q[14];
    rd_s    = fp32_q ? norm_q[0] : |norm_q[13:0];
    rd_inc  = !rm_q && rd_g && (rd_r || rd_s || rd_kept[0]);
    rd_sum  = {1'b0, rd_kept} + {24'b0, rd_inc};
    rd_cy   = fp32_q ? rd_sum[24] : rd_sum[11];
    rd_man  = rd_cy ? rd_sum[24:1] : rd_sum[23:0];
    rd_exp  = rd_cy ? exp_q + 10'd1 : exp_q;
    rd_hid  = fp32_q ? rd_man[23] : rd_man[10];
    rd_ef   = rd_hid ? rd_exp : 10'd0;
    rd_nx   = rd_g | rd_r | rd_s;
    rd_sign = sgn_q && !(sub_q && (norm_q == '0));
    rd_ovf  = rd_ef >= (fp32_q ? 10'd255 : 10'd31);
    if (spec_q) begin
      rd_res = spec_res_q;
      rd_flg = spec_flg_q;
    end else if (rd_ovf) begin
      rd_res = round_ovf(rd_sign);
      rd_flg = 5'b00101;
    end else begin
      rd_res = fp32_q ? {rd_sign, rd_ef[7:0], rd_man[22:0]}
                      : {16'h0, rd_sign, rd_ef[4:0], rd_man[9:0]};
      rd_flg = {3'b000, !rd_hid && rd_nx, rd_nx};
    end
  end

  function automatic logic [31:0] round_ovf(input logic s);
    return rm_q ? maxf_of(s, fp32_q) : inf_of(s, fp32_q);
  endfunction

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    ready_d    = ready_q;
    result_d   = result_q;
    flags_d    = flags_q;
    a_d        = a_q;
    b_d        = b_q;
    opc_d      = opc_q;
    rm_d       = rm_q;
    fp32_d     = fp32_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    ea_d       = ea_q;
    eb_d       = eb_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    spec_flg_d = spec_flg_q;
    sgn_d      = sgn_q;
    sub_d      = sub_q;
    exp_d      = exp_q;
    big_d      = big_q;
    small_d    = small_q;
    sum_d      = sum_q;
    norm_d     = norm_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          opc_d   = op_code;
          rm_d    = round_mode;
          fp32_d  = mode_fp;
          ready_d = 1'b0;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sa_d       = ua.sign;
        sb_d       = up_sb;
        ea_d       = ua.exp;
        eb_d       = ub.exp;
        ma_d       = ua.man;
        mb_d       = ub.man;
        spec_d     = up_spec;
        spec_res_d = up_res;
        spec_flg_d = up_flg;
        state_d    = S_ALIGN;
      end
      S_ALIGN: begin
        sgn_d   = al_swap ? sb_q : sa_q;
        sub_d   = sa_q ^ sb_q;
        exp_d   = al_swap ? eb_q : ea_q;
        big_d   = al_big;
        small_d = al_small;
        state_d = S_ADD;
      end
      S_ADD: begin
        sum_d   = sub_q ? ({1'b0, big_q, 3'b000} - {1'b0, small_q})
                        : ({1'b0, big_q, 3'b000} + {1'b0, small_q});
        state_d = S_NORM;
      end
      S_NORM: begin
        norm_d  = nm_man;
        exp_d   = nm_exp;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        result_d = rd_res;
        flags_d  = rd_flg;
        valid_d  = 1'b1;
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (ready_in) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q        <= a_d;
    b_q        <= b_d;
    opc_q      <= opc_d;
    rm_q       <= rm_d;
    fp32_q     <= fp32_d;
    sa_q       <= sa_d;
    sb_q       <= sb_d;
    ea_q       <= ea_d;
    eb_q       <= eb_d;
    ma_q       <= ma_d;
    mb_q       <= mb_d;
    spec_q     <= spec_d;
    spec_res_q <= spec_res_d;
    spec_flg_q <= spec_flg_d;
    sgn_q      <= sgn_d;
    sub_q      <= sub_d;
    exp_q      <= exp_d;
    big_q      <= big_d;
    small_q    <= small_d;
    sum_q      <= sum_d;
    norm_q     <= norm_d;
  end

  assign valid_out = valid_q;
  assign ready_out = ready_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_float_alu_core.sv
// Bench for float_alu_core: exact-integer reference model, per-cycle output compare, directed vectors.
module tb_float_alu_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] op_a, op_b;
  logic [2:0]  op_code;
  logic        round_mode, mode_fp, start, ready_in;
  logic        valid_out, ready_out;
  logic [31:0] result;
  logic [4:0]  flags;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_res = '0;
  logic [4:0]  exp_flg = '0;
  bit          chk_en = 1'b0;

  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b011;

  float_alu_core dut (
    .clk(clk), .rst(rst), .op_a(op_a), .op_b(op_b), .op_code(op_code),
    .round_mode(round_mode), .mode_fp(mode_fp), .start(start), .ready_in(ready_in),
    .valid_out(valid_out), .ready_out(ready_out), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] fpack(input logic s, input int unsigned e,
                                        input logic [319:0] f, input logic fp);
    logic [31:0] ev, fv;
    ev = e;
    fv = f[31:0];
    return fp ? {s, ev[7:0], fv[22:0]} : {16'h0, s, ev[4:0], fv[9:0]};
  endfunction

  // Reference: exact sum as an integer in units of the smallest subnormal, then rounded to format
  function automatic void model(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b,
                                input logic rm, input logic fp,
                                output logic [31:0] res, output logic [4:0] flg);
    int unsigned fw, emax, ea, eb, p, sh, e;
    logic [31:0]  fa, fb, qnan;
    logic         sa, sb, s, nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, nx;
    logic [319:0] va, vb, m, kept, rem, half;
    fw   = fp ? 23 : 10;
    emax = fp ? 255 : 31;
    qnan = fp ? 32'h7FC00000 : 32'h00007E00;
    if (fp) begin
      sa = a[31]; ea = a[30:23]; fa = {9'b0, a[22:0]};
      sb = b[31]; eb = b[30:23]; fb = {9'b0, b[22:0]};
    end else begin
      sa = a[15]; ea = a[14:10]; fa = {22'b0, a[9:0]};
      sb = b[15]; eb = b[14:10]; fb = {22'b0, b[9:0]};
    end
    sb     = sb ^ (opc == SUB);
    nan_a  = (ea == emax) && (fa != 0);
    nan_b  = (eb == emax) && (fb != 0);
    snan_a = nan_a && !fa[fw-1];
    snan_b = nan_b && !fb[fw-1];
    inf_a  = (ea == emax) && (fa == 0);
    inf_b  = (eb == emax) && (fb == 0);
    res = qnan;
    flg = 5'b10000;
    if (opc != ADD && opc != SUB) begin
      flg = 5'b10000;
    end else if (nan_a || nan_b) begin
      flg = (snan_a || snan_b) ? 5'b10000 : 5'b00000;
    end else if (inf_a && inf_b && sa != sb) begin
      flg = 5'b10000;
    end else if (inf_a || inf_b) begin
      res = fpack(inf_a ? sa : sb, emax, '0, fp);
      flg = '0;
    end else begin
      va = ((ea != 0) ? ((320'd1 << fw) | 320'(fa)) : 320'(fa)) << ((ea == 0) ? 0 : ea - 1);
      vb = ((eb != 0) ? ((320'd1 << fw) | 320'(fb)) : 320'(fb)) << ((eb == 0) ? 0 : eb - 1);
      if (sa == sb)     begin m = va + vb; s = sa; end
      else if (va >= vb) begin m = va - vb; s = sa; end
      else              begin m = vb - va; s = sb; end
      if (m == 0) s = (sa == sb) ? sa : 1'b0;
      p = 0;
      for (int unsigned i = 0; i < 320; i++) if (m[i]) p = i;
      sh   = (p > fw) ? p - fw : 0;
      kept = m >> sh;
      rem  = m & ((320'd1 << sh) - 1);
      half = (sh != 0) ? (320'd1 << (sh - 1)) : '0;
      nx   = (rem != 0);
      if (!rm && sh != 0 && (rem > half || (rem == half && kept[0]))) kept = kept + 1;
      if (kept == (320'd1 << (fw + 1))) begin kept = kept >> 1; sh = sh + 1; end
      e = (kept >= (320'd1 << fw)) ? sh + 1 : 0;
      if (e >= emax) begin
        res = rm ? fpack(s, emax - 1, '1, fp) : fpack(s, emax, '0, fp);
        flg = 5'b00101;
      end else begin
        res = fpack(s, e, kept, fp);
        flg = {3'b000, (e == 0) && nx, nx};
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (chk_en) begin
        check("result", result, exp_res);
        check("flags", {27'b0, flags}, {27'b0, exp_flg});
      end else begin
        check("valid_early", {31'b0, valid_out}, 32'd0);
      end
    end
  end

  task automatic run_op(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b,
                        input logic rm, input logic fp, input logic [31:0] lit_res,
                        input logic [4:0] lit_flg, input int hold, input bit poke);
    logic [31:0] mres;
    logic [4:0]  mflg;
    int          n;
    model(opc, a, b, rm, fp, mres, mflg);
    check("model_res", mres, lit_res);
    check("model_flg", {27'b0, mflg}, {27'b0, lit_flg});
    @(negedge clk);
    chk_en = 1'b0;
    op_a = a; op_b = b; op_code = opc; round_mode = rm; mode_fp = fp;
    start = 1'b1; ready_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    op_a = ~a; op_b = ~b; op_code = ~opc; round_mode = ~rm; mode_fp = ~fp;
    check("busy_ready", {31'b0, ready_out}, 32'd0);
    n = 0;
    if (poke) begin
      op_a = 32'h3F800000; op_b = 32'h3F800000; op_code = ADD; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
    end
    while (!valid_out && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'd5);
    exp_res = mres;
    exp_flg = mflg;
    chk_en  = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("valid_hold", {31'b0, valid_out}, 32'd1);
    end
    @(negedge clk);
    ready_in = 1'b1;
    @(posedge clk); #1;
    ready_in = 1'b0;
    check("consume_valid", {31'b0, valid_out}, 32'd0);
    check("consume_ready", {31'b0, ready_out}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; ready_in = 1'b0;
    op_a = '0; op_b = '0; op_code = ADD; round_mode = 1'b0; mode_fp = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, ready_out}, 32'd1);
    check("rst_valid", {31'b0, valid_out}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {27'b0, flags}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(ADD, 32'h41A60000, 32'h40100000, 0, 1, 32'h41B80000, 5'b00000, 3, 0);
    run_op(ADD, 32'h41600000, 32'hC1440000, 0, 1, 32'h3FE00000, 5'b00000, 0, 1);
    run_op(ADD, 32'h41020000, 32'hC1040000, 0, 1, 32'hBE000000, 5'b00000, 0, 0);
    run_op(ADD, 32'h40A80000, 32'h41940000, 0, 1, 32'h41BE0000, 5'b00000, 1, 0);
    run_op(ADD, 32'h3F800000, 32'h33800000, 0, 1, 32'h3F800000, 5'b00001, 0, 0);
    run_op(SUB, 32'h3F800000, 32'h3F800000, 0, 1, 32'h00000000, 5'b00000, 0, 0);
    run_op(ADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 1, 32'h7F800000, 5'b00101, 0, 0);
    run_op(ADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 1, 1, 32'h7F7FFFFF, 5'b00101, 0, 0);
    run_op(ADD, 32'h7F800000, 32'hFF800000, 0, 1, 32'h7FC00000, 5'b10000, 0, 0);
    run_op(ADD, 32'h00003C00, 32'h00003C00, 0, 0, 32'h00004000, 5'b00000, 0, 0);
    run_op(3'b000, 32'h3F800000, 32'h3F800000, 0, 1, 32'h7FC00000, 5'b10000, 0, 0);
    run_op(3'b111, 32'h00003C00, 32'h00003C00, 0, 0, 32'h00007E00, 5'b10000, 0, 1);
    run_op(ADD, 32'h7F800001, 32'h3F800000, 0, 1, 32'h7FC00000, 5'b10000, 0, 0);
    run_op(ADD, 32'h7FC00001, 32'h00000000, 0, 1, 32'h7FC00000, 5'b00000, 0, 0);
    run_op(ADD, 32'hFF800000, 32'h3F800000, 0, 1, 32'hFF800000, 5'b00000, 0, 0);
    run_op(SUB, 32'h7F800000, 32'h7F800000, 1, 1, 32'h7FC00000, 5'b10000, 0, 0);
    run_op(ADD, 32'h80000000, 32'h80000000, 0, 1, 32'h80000000, 5'b00000, 0, 0);
    run_op(SUB, 32'h80000000, 32'h00000000, 0, 1, 32'h80000000, 5'b00000, 0, 0);
    run_op(ADD, 32'h3F800000, 32'h33C00000, 1, 1, 32'h3F800000, 5'b00001, 0, 0);
    run_op(ADD, 32'h3F800000, 32'h33C00000, 0, 1, 32'h3F800001, 5'b00001, 0, 0);
    run_op(ADD, 32'h00000001, 32'h00000001, 0, 1, 32'h00000002, 5'b00000, 0, 0);
    run_op(SUB, 32'h00800000, 32'h00000001, 0, 1, 32'h007FFFFF, 5'b00000, 0, 0);
    run_op(SUB, 32'h3F800001, 32'h3F800000, 0, 1, 32'h34000000, 5'b00000, 0, 0);
    run_op(ADD, 32'h00007BFF, 32'h00007BFF, 0, 0, 32'h00007C00, 5'b00101, 0, 0);
    run_op(ADD, 32'h00007BFF, 32'h00007BFF, 1, 0, 32'h00007BFF, 5'b00101, 0, 0);
    run_op(ADD, 32'hFFFF3C00, 32'h12341000, 0, 0, 32'h00003C00, 5'b00001, 0, 0);
    run_op(ADD, 32'h00000001, 32'h00008000, 0, 0, 32'h00000001, 5'b00000, 0, 0);
    run_op(ADD, 32'h00007D00, 32'h00003C00, 0, 0, 32'h00007E00, 5'b10000, 0, 0);

    // reset while an operation is in flight
    @(negedge clk);
    chk_en = 1'b0;
    op_a = 32'h41A60000; op_b = 32'h40100000; op_code = ADD; round_mode = 1'b0; mode_fp = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ready", {31'b0, ready_out}, 32'd1);
    check("midrst_valid", {31'b0, valid_out}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_flags", {27'b0, flags}, 32'd0);
    exp_res = '0;
    exp_flg = '0;
    chk_en  = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("midrst_quiet", {31'b0, valid_out}, 32'd0);

    run_op(ADD, 32'h40A80000, 32'h41940000, 0, 1, 32'h41BE0000, 5'b00000, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
